dfx_rp_ctrl: RTL
================

# dfx_rp_ctrl

Sequencing controller for the reconfigurable partitions (LED counter RPs) in the top-level IO design. It accepts a software reconfiguration request for one RP, decouples and safes that RP's output, waits for the PR engine to report completion, and pulses the RP reset. It then re-couples the RP. It sits between the AXI-lite register block (request/status) and the RP instances, and drives the LED outputs toward the board pins.

## Interface
- NUM_RP, 3, number of reconfigurable partitions (>=2); RP_W = $clog2(NUM_RP)
- DRAIN_CYC, 16, cycles an RP is decoupled before the PR-wait phase (>=1)
- RST_CYC, 8, cycles the RP reset is held after PR done (>=1)
- TIMEOUT_CYC, 2**24, PR-wait watchdog limit (~168 ms at 100 MHz)
- SAFE_VAL, '0, NUM_RP-bit value driven on led_o for decoupled RPs
- clk100  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_i  in  1  start request, sampled only in IDLE
- rp_sel_i  in  RP_W  RP index for req_i
- clr_i  in  1  clears FAULT
- pr_done_i  in  1  PR engine completion pulse
- pr_err_i  in  1  PR engine error pulse
- rp_led_i  in  NUM_RP  raw RP outputs
- led_o  out  NUM_RP  gated, registered RP outputs
- decouple_o  out  NUM_RP  per-RP decouple
- rp_rst_o  out  NUM_RP  per-RP reset (active-high)
- ack_o  out  1  1-cycle pulse: request accepted
- done_o  out  1  1-cycle pulse: sequence completed OK
- busy_o  out  1  high in every state but IDLE
- fault_o  out  1  high in FAULT
- status_o  out  2  last result: 0 OK, 1 PR error, 2 timeout, 3 bad index
- cur_rp_o  out  RP_W  index latched at acceptance

## Operation
- States: IDLE, DRAIN, WAIT_PR, RESET, RELEASE, FAULT.
- IDLE: req_i with rp_sel_i < NUM_RP latches the index, sets decouple_o[sel], and enters DRAIN with ack_o=1.
  - req_i with rp_sel_i >= NUM_RP is rejected: status_o=3, no ack_o, state stays IDLE.
  - req_i in any non-IDLE state is ignored (not queued).
- DRAIN: counts DRAIN_CYC cycles, then enters WAIT_PR. pr_done_i/pr_err_i pulses arriving in DRAIN are latched and acted on in the first WAIT_PR cycle.
- WAIT_PR:
  - pr_err_i (or latched err) -> FAULT, status_o=1.
  - pr_done_i (or latched done) -> RESET.
  - Simultaneous done and err: err wins.
- RESET: rp_rst_o[sel]=1 for exactly RST_CYC cycles, then RELEASE.
- RELEASE: rp_rst_o[sel]=0, decouple_o[sel] stays 1 for this one cycle. Then IDLE with decouple_o[sel]=0, done_o=1, status_o=0.
- FAULT: decouple_o[sel]=1, rp_rst_o[sel]=1, fault_o=1.
  - clr_i -> IDLE. RP `sel` stays quarantined (decouple and reset held) until a later sequence on that index completes OK.
  - Quarantine bits of other RPs are unaffected.
- Quarantine is a per-RP NUM_RP-bit register.
  - decouple_o = quarantine OR active-sequence mask.
  - rp_rst_o is formed the same way.
- led_o[i] <= decouple_o[i] ? SAFE_VAL[i] : rp_led_i[i], registered.

## Timing
- Reset values: state IDLE, all outputs 0 except led_o=SAFE_VAL; quarantine, latched done/err and counters cleared.
- rst mid-sequence aborts immediately; next cycle shows reset values.
- req_i at cycle T -> ack_o, busy_o, decouple_o[sel] high at T+1.
- WAIT_PR entered at T+1+DRAIN_CYC.
- pr_done_i at cycle P in WAIT_PR -> rp_rst_o high P+1..P+RST_CYC; RELEASE at P+RST_CYC+1; done_o and decouple_o low at P+RST_CYC+2.
- led_o reflects decouple_o with 1-cycle latency.
- Counters use the minimum width that holds their parameter; no wrap: they saturate at terminal count and are reloaded on state entry.

## Configuration
- DFX_RP_CTRL_TIMEOUT_EN defined:
  - watchdog counts WAIT_PR cycles; reaching TIMEOUT_CYC -> FAULT, status_o=2;
  - pr_done_i in the same cycle as expiry wins.
- Undefined: no watchdog logic; WAIT_PR waits indefinitely; status_o never 2.

## Structure
- Package dfx_rp_ctrl_pkg:
  - state enum;
  - status code constants (ST_OK, ST_PR_ERR, ST_TIMEOUT, ST_BAD_IDX).
- Sub-module dfx_cyc_timer: loadable saturating down-counter with terminal-count flag. Instantiated for DRAIN/RESET and for the watchdog.

## Test plan
- NUM_RP=3, req_i sel=1, pr_done_i 5 cycles into WAIT_PR -> ack at T+1; decouple_o=3'b010 for DRAIN+5+8+1 cycles; rp_rst_o high 8 cycles; done_o; status_o=0.
- pr_done_i and pr_err_i same cycle -> FAULT, fault_o=1, status_o=1; clr_i -> IDLE with decouple_o[1]/rp_rst_o[1] still 1; next OK sequence on sel=1 clears them.
- req_i sel=3 -> no ack_o, status_o=3, busy_o=0.
- Second req_i during WAIT_PR -> ignored; cur_rp_o unchanged.
- With DFX_RP_CTRL_TIMEOUT_EN, TIMEOUT_CYC=100, no done -> FAULT at WAIT_PR+100, status_o=2.
- rst asserted in RESET -> next cycle all outputs 0, led_o=SAFE_VAL; rp_led_i=3'b111 with sel=0 decoupled -> led_o=3'b110.

Source files
------------

// File: rtl/dfx_rp_ctrl_pkg.sv
// dfx_rp_ctrl_pkg
// Shared types for the reconfigurable-partition sequencing controller:
//   state_e  - sequencer FSM states
//   status_e - last-result codes reported on status_o
//   max_int  - elaboration helper used to size the shared phase timer
package dfx_rp_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_WAIT_PR = 3'd2,
    S_RESET   = 3'd3,
    S_RELEASE = 3'd4,
    S_FAULT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_PR_ERR  = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_BAD_IDX = 2'd3
  } status_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dfx_cyc_timer.sv
// dfx_cyc_timer
// Loadable down-counter that saturates at zero. tc_o is high while the count
// is zero, so loading N-1 on state entry yields a terminal count in the Nth
// cycle of that state.
// Ports:
//   clk100     - clock
//   rst        - synchronous active-high reset (count cleared)
//   load_i     - load load_val_i on the next edge
//   load_val_i - value to load
//   tc_o       - terminal count (count == 0)
module dfx_cyc_timer #(
  parameter int W = 4
) (
  input  logic         clk100,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/dfx_rp_ctrl.sv
// dfx_rp_ctrl
// Sequences a reconfiguration of one reconfigurable partition: decouple and
// drain, wait for the PR engine, pulse the RP reset, re-couple. A failed
// sequence leaves the RP quarantined (decoupled and held in reset) until a
// later sequence on the same index completes.
// Optional watchdog on the PR-wait phase: define DFX_RP_CTRL_TIMEOUT_EN.
// Ports:
//   clk100, rst              - clock, synchronous active-high reset
//   req_i, rp_sel_i          - start request and RP index (taken only in IDLE)
//   clr_i                    - leave FAULT
//   pr_done_i, pr_err_i      - PR engine completion / error pulses
//   rp_led_i                 - raw RP outputs
//   led_o                    - registered RP outputs, SAFE_VAL where decoupled
//   decouple_o, rp_rst_o     - per-RP decouple and reset
//   ack_o, done_o            - accept / successful-completion pulses
//   busy_o, fault_o          - not IDLE / in FAULT
//   status_o                 - last result code
//   cur_rp_o                 - index latched at acceptance
//
// state     | meaning
// IDLE      | waiting for a request
// DRAIN     | RP decoupled, letting in-flight traffic settle
// WAIT_PR   | waiting for PR engine done/error
// RESET     | RP reset asserted after PR done
// RELEASE   | reset released, still decoupled for one cycle
// FAULT     | PR error or timeout, RP held decoupled and in reset
module dfx_rp_ctrl
  import dfx_rp_ctrl_pkg::*;
#(
  parameter int                NUM_RP    = 3,
  localparam int               RP_W      = $clog2(NUM_RP),
  parameter int                DRAIN_CYC = 16,
  parameter int                RST_CYC   = 8,
`ifdef DFX_RP_CTRL_TIMEOUT_EN
  parameter int                TIMEOUT_CYC = 2**24,
`endif
  parameter logic [NUM_RP-1:0] SAFE_VAL  = '0
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              req_i,
  input  logic [RP_W-1:0]   rp_sel_i,
  input  logic              clr_i,
  input  logic              pr_done_i,
  input  logic              pr_err_i,
  input  logic [NUM_RP-1:0] rp_led_i,
  output logic [NUM_RP-1:0] led_o,
  output logic [NUM_RP-1:0] decouple_o,
  output logic [NUM_RP-1:0] rp_rst_o,
  output logic              ack_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              fault_o,
  output logic [1:0]        status_o,
  output logic [RP_W-1:0]   cur_rp_o
);

  // DRAIN and RESET never overlap, so they share one timer sized for the larger.
  localparam int            TW       = $clog2(max_int(DRAIN_CYC, RST_CYC) + 1);
  localparam logic [TW-1:0] DRAIN_LD = TW'(DRAIN_CYC - 1);
  localparam logic [TW-1:0] RST_LD   = TW'(RST_CYC - 1);

  state_e              state_q, state_d;
  status_e             status_q, status_d;
  logic [RP_W-1:0]     cur_rp_q, cur_rp_d;
  logic [NUM_RP-1:0]   quar_q, quar_d;
  logic [NUM_RP-1:0]   led_q;
  logic                done_lat_q, done_lat_d;
  logic                err_lat_q, err_lat_d;
  logic                ack_q, ack_d;
  logic                done_q, done_d;

  logic                tmr_load, tmr_tc;
  logic [TW-1:0]       tmr_val;
  logic [NUM_RP-1:0]   act_bit, act_dec, act_rst;
  logic                sel_ok, done_eff, err_eff;

  dfx_cyc_timer #(.W(TW)) u_phase_tmr (
    .clk100     (clk100),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

`ifdef DFX_RP_CTRL_TIMEOUT_EN
  localparam int            WW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WD_LD = WW'(TIMEOUT_CYC - 1);
  logic wd_load, wd_tc;

  dfx_cyc_timer #(.W(WW)) u_wd_tmr (
    .clk100     (clk100),
    .rst        (rst),
    .load_i     (wd_load),
    .load_val_i (WD_LD),
    .tc_o       (wd_tc)
  );
`endif

  assign sel_ok   = int'(rp_sel_i) < NUM_RP;
  assign act_bit  = NUM_RP'(1) << cur_rp_q;
  // Pulses seen during DRAIN are honoured on the first WAIT_PR cycle.
  assign done_eff = pr_done_i | done_lat_q;
  assign err_eff  = pr_err_i  | err_lat_q;

  always_comb begin
    act_dec = '0;
    act_rst = '0;
    case (state_q)
      S_DRAIN, S_WAIT_PR, S_RELEASE: act_dec = act_bit;
      S_RESET, S_FAULT: begin
        act_dec = act_bit;
        act_rst = act_bit;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    cur_rp_d   = cur_rp_q;
    quar_d     = quar_q;
    done_lat_d = done_lat_q;
    err_lat_d  = err_lat_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = DRAIN_LD;
`ifdef DFX_RP_CTRL_TIMEOUT_EN
    wd_load    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (sel_ok) begin
            cur_rp_d   = rp_sel_i;
            ack_d      = 1'b1;
            done_lat_d = 1'b0;
            err_lat_d  = 1'b0;
            tmr_load   = 1'b1;
            tmr_val    = DRAIN_LD;
            state_d    = S_DRAIN;
          end else begin
            status_d = ST_BAD_IDX;
          end
        end
      end
      S_DRAIN: begin
        if (pr_done_i) done_lat_d = 1'b1;
        if (pr_err_i)  err_lat_d  = 1'b1;
        if (tmr_tc) begin
          state_d = S_WAIT_PR;
`ifdef DFX_RP_CTRL_TIMEOUT_EN
          wd_load = 1'b1;
`endif
        end
      end
      S_WAIT_PR: begin
        // Error beats done; done beats a watchdog expiry in the same cycle.
        if (err_eff) begin
          status_d = ST_PR_ERR;
          quar_d   = quar_q | act_bit;
          state_d  = S_FAULT;
        end else if (done_eff) begin
          tmr_load = 1'b1;
          tmr_val  = RST_LD;
          state_d  = S_RESET;
        end
`ifdef DFX_RP_CTRL_TIMEOUT_EN
        else if (wd_tc) begin
          status_d = ST_TIMEOUT;
          quar_d   = quar_q | act_bit;
          state_d  = S_FAULT;
        end
`endif
      end
      S_RESET: begin
        if (tmr_tc) begin
          // Reset pulse done: lift any quarantine so RELEASE shows reset low.
          quar_d  = quar_q & ~act_bit;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        done_d   = 1'b1;
        status_d = ST_OK;
        state_d  = S_IDLE;
      end
      S_FAULT: begin
        if (clr_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q    <= S_IDLE;
      status_q   <= ST_OK;
      cur_rp_q   <= '0;
      quar_q     <= '0;
      done_lat_q <= 1'b0;
      err_lat_q  <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      led_q      <= SAFE_VAL;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      cur_rp_q   <= cur_rp_d;
      quar_q     <= quar_d;
      done_lat_q <= done_lat_d;
      err_lat_q  <= err_lat_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      led_q      <= (decouple_o & SAFE_VAL) | (~decouple_o & rp_led_i);
    end
  end

  assign decouple_o = quar_q | act_dec;
  assign rp_rst_o   = quar_q | act_rst;
  assign led_o      = led_q;
  assign ack_o      = ack_q;
  assign done_o     = done_q;
  assign busy_o     = (state_q != S_IDLE);
  assign fault_o    = (state_q == S_FAULT);
  assign status_o   = status_q;
  assign cur_rp_o   = cur_rp_q;

endmodule
